// File: rtl/dds_freq_display.sv
// Decodes a DDS phase reload constant back into carrier frequency (100 kHz units),
// then into four BCD digits and active-low seven-segment patterns, using a multi-cycle datapath.
module dds_freq_display #(
   parameter int unsigned width_dds = 32,
   parameter int unsigned fs_units  = 2400
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [width_dds-1:0] K,
   input  logic                 load,
   output logic                 busy,
   output logic                 done,
   output logic [11:0]          freq,
   output logic [15:0]          bcd,
   output logic [3:0][6:0]      HEX
);

   localparam int unsigned     wacc = width_dds + 12;
   localparam logic [11:0]     fs   = 12'(fs_units);
   localparam logic [wacc-1:0] half = wacc'(1) << (width_dds - 1);

   typedef enum logic [2:0] {IDLE, MUL, ROUND, BCD, SHOW} state_t;

   state_t               state;
   logic [width_dds-1:0] k_lat;
   logic [wacc-1:0]      acc;
   logic [wacc-1:0]      rnd_sum;
   logic [3:0]           cnt;
   logic [11:0]          bin;
   logic [27:0]          dd;
   logic [27:0]          dd_adj;
   logic [27:0]          dd_next;

   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'd0:    seg = 7'h3f;
         4'd1:    seg = 7'h06;
         4'd2:    seg = 7'h5b;
         4'd3:    seg = 7'h4f;
         4'd4:    seg = 7'h66;
         4'd5:    seg = 7'h6d;
         4'd6:    seg = 7'h7d;
         4'd7:    seg = 7'h07;
         4'd8:    seg = 7'h7f;
         4'd9:    seg = 7'h6f;
         default: seg = 7'h00;
      endcase
   endfunction

   always_comb begin
      rnd_sum = acc + half;
   end

   // One double-dabble step: bcd digits sit in dd[27:12], the binary shifts out of dd[11:0].
   always_comb begin
      dd_adj = dd;
      for (int unsigned d = 0; d < 4; d++) begin
         if (dd_adj[12 + 4*d +: 4] >= 4'd5)
            dd_adj[12 + 4*d +: 4] = dd_adj[12 + 4*d +: 4] + 4'd3;
      end
      dd_next = dd_adj << 1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         freq  <= '0;
         bcd   <= '0;
         HEX   <= '1;
         k_lat <= '0;
         acc   <= '0;
         cnt   <= '0;
         bin   <= '0;
         dd    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  k_lat <= K;
                  acc   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= MUL;
               end
            end
            MUL: begin
               if (fs[cnt])
                  acc <= acc + (wacc'(k_lat) << cnt);
               if (cnt == 4'd11) begin
                  cnt   <= '0;
                  state <= ROUND;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            ROUND: begin
               bin   <= rnd_sum[wacc-1 -: 12];
               dd    <= {16'h0000, rnd_sum[wacc-1 -: 12]};
               state <= BCD;
            end
            BCD: begin
               dd <= dd_next;
               if (cnt == 4'd11) begin
                  cnt   <= '0;
                  state <= SHOW;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            SHOW: begin
               freq <= bin;
               bcd  <= dd[27:12];
               for (int unsigned i = 0; i < 4; i++)
                  HEX[i] <= ~seg(dd[12 + 4*i +: 4]);
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
